// File: rtl/button_debouncer_multi.sv
// button_debouncer_multi
// Multi-channel push-button conditioner. Each channel synchronises its raw
// input, debounces it with a 2^CNT_WIDTH-cycle stability counter, and emits
// one-cycle press / release / long-press pulses from the debounced level.
// Optional feature: define DEBOUNCER_AUTOREPEAT_EN to add auto-repeat press
// pulses every REPEAT_CYCLES once a long press has been reported.
module button_debouncer_multi #(
    parameter int CHANNELS      = 5,
    parameter int CNT_WIDTH     = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_long
);

    // Hold counter saturates at LONG_CYCLES, so it needs room for that value.
    localparam int                    HOLD_W        = $clog2(LONG_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX       = {CNT_WIDTH{1'b1}};
    localparam logic [HOLD_W-1:0]     HOLD_SAT      = HOLD_W'(LONG_CYCLES);
    // btn_long is registered, so it is raised on the edge that moves the
    // hold counter from LONG_CYCLES-2 to LONG_CYCLES-1.
    localparam logic [HOLD_W-1:0]     HOLD_PRE_LONG = HOLD_W'(LONG_CYCLES - 2);
`ifdef DEBOUNCER_AUTOREPEAT_EN
    localparam int                    REP_W         = $clog2(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0]     HOLD_LONG     = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]      REP_LAST      = REP_W'(REPEAT_CYCLES - 1);
`endif

    // Reject parameter sets outside the supported ranges at elaboration.
    if (CHANNELS < 1 || CHANNELS > 32 || CNT_WIDTH < 1 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_debouncer_multi: illegal parameter set");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   sync_s;
        logic [CNT_WIDTH-1:0]   cnt_r;
        logic [CNT_WIDTH-1:0]   cnt_nxt_s;
        logic                   state_r;
        logic                   state_nxt_s;
        logic                   toggle_s;
        logic [HOLD_W-1:0]      hold_r;
        logic [HOLD_W-1:0]      hold_nxt_s;
        logic                   press_s;
        logic                   release_s;
        logic                   long_s;
        logic                   press_r;
        logic                   release_r;
        logic                   long_r;

        // Only the last synchroniser stage is allowed to reach the logic.
        assign sync_s = sync_r[SYNC_STAGES-1];

        // Debounce: count consecutive disagreement; toggle once it has lasted 2^CNT_WIDTH cycles.
        always_comb begin
            state_nxt_s = state_r;
            toggle_s    = 1'b0;
            cnt_nxt_s   = '0;
            if (sync_s == state_r) begin
                cnt_nxt_s = '0;
            end else if (cnt_r == CNT_MAX) begin
                toggle_s    = 1'b1;
                state_nxt_s = ~state_r;
                cnt_nxt_s   = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
            end
        end

        // Hold timing: count while pressed, saturate, and flag the long-press point once.
        always_comb begin
            hold_nxt_s = '0;
            long_s     = 1'b0;
            if (!state_r || toggle_s) begin
                hold_nxt_s = '0;
            end else if (hold_r == HOLD_SAT) begin
                hold_nxt_s = hold_r;
            end else begin
                hold_nxt_s = hold_r + HOLD_W'(1);
            end
            // A release toggle on the same edge wins, so long never coincides with release.
            if (state_r && !toggle_s && (hold_r == HOLD_PRE_LONG)) begin
                long_s = 1'b1;
            end else begin
                long_s = 1'b0;
            end
        end

        assign release_s = toggle_s & state_r;

`ifdef DEBOUNCER_AUTOREPEAT_EN
        logic [REP_W-1:0] rep_r;
        logic [REP_W-1:0] rep_nxt_s;
        logic             rep_fire_s;

        // Auto-repeat: after the long-press point, fire a press every REPEAT_CYCLES of hold.
        always_comb begin
            rep_nxt_s  = '0;
            rep_fire_s = 1'b0;
            if (state_r && !toggle_s && (hold_r >= HOLD_LONG)) begin
                if (rep_r == REP_LAST) begin
                    rep_fire_s = 1'b1;
                    rep_nxt_s  = '0;
                end else begin
                    rep_nxt_s = rep_r + REP_W'(1);
                end
            end else begin
                rep_nxt_s = '0;
            end
        end

        // Repeat counter register, cleared by reset and whenever not armed.
        always_ff @(posedge CLK100MHZ) begin
            if (!CPU_RESETN) begin
                rep_r <= '0;
            end else begin
                rep_r <= rep_nxt_s;
            end
        end

        assign press_s = (toggle_s & ~state_r) | rep_fire_s;
`else
        assign press_s = toggle_s & ~state_r;
`endif

        // Channel state: synchroniser, counters, debounced level and event pulses.
        always_ff @(posedge CLK100MHZ) begin
            if (!CPU_RESETN) begin
                sync_r    <= '0;
                cnt_r     <= '0;
                state_r   <= 1'b0;
                hold_r    <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                sync_r    <= {sync_r[SYNC_STAGES-2:0], btn_in[g]};
                cnt_r     <= cnt_nxt_s;
                state_r   <= state_nxt_s;
                hold_r    <= hold_nxt_s;
                press_r   <= press_s;
                release_r <= release_s;
                long_r    <= long_s;
            end
        end

        assign btn_state[g]   = state_r;
        assign btn_press[g]   = press_r;
        assign btn_release[g] = release_r;
        assign btn_long[g]    = long_r;
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// tb_button_debouncer_multi
// Self-checking bench for button_debouncer_multi (CHANNELS=2, CNT_WIDTH=4,
// SYNC_STAGES=2, LONG_CYCLES=40, REPEAT_CYCLES=10). An event-level reference
// model predicts every output each cycle; directed scenarios add absolute
// timing checks.
module tb_button_debouncer_multi;

    localparam int CH    = 2;
    localparam int CNT_W = 4;
    localparam int SYNC  = 2;
    localparam int LONG  = 40;
    localparam int REP   = 10;
    localparam int DEB   = 1 << CNT_W;
    localparam int MAXC  = 4096;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] btn;
    logic [CH-1:0] btn_state;
    logic [CH-1:0] btn_press;
    logic [CH-1:0] btn_release;
    logic [CH-1:0] btn_long;

    // Reference model state
    int            cyc;
    bit            rst_log [MAXC];
    bit [CH-1:0]   raw_log [MAXC];
    logic [CH-1:0] m_state;
    logic [CH-1:0] m_press;
    logic [CH-1:0] m_release;
    logic [CH-1:0] m_long;
    int            press_t [CH];

    int n_tests;
    int n_fail;

    button_debouncer_multi #(
        .CHANNELS     (CH),
        .CNT_WIDTH    (CNT_W),
        .SYNC_STAGES  (SYNC),
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .btn_in     (btn),
        .btn_state  (btn_state),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level seen by the debouncer at edge e: raw input two edges earlier,
    // forced low if a reset edge intervened.
    function automatic bit seen_at(int e, int ch);
        if (e < 3) return 1'b0;
        if (rst_log[e-1] || rst_log[e-2]) return 1'b0;
        return raw_log[e-2][ch];
    endfunction

    // Advance one clock edge and update the model with the inputs sampled there.
    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 1);
            $fatal(1);
        end
        rst_log[cyc] = !rst_n;
        raw_log[cyc] = btn;
        m_press   = '0;
        m_release = '0;
        m_long    = '0;
        if (!rst_n) begin
            m_state = '0;
            for (int ch = 0; ch < CH; ch++) press_t[ch] = -1;
        end else begin
            for (int ch = 0; ch < CH; ch++) begin
                bit win;
                win = 1'b1;
                // Toggle when the last DEB edges all disagreed with the state, without reset.
                for (int k = 0; k < DEB; k++) begin
                    if (cyc - k < 1) win = 1'b0;
                    else if (rst_log[cyc-k] || (seen_at(cyc - k, ch) == m_state[ch])) win = 1'b0;
                end
                if (win) begin
                    if (m_state[ch] == 1'b0) begin
                        m_press[ch] = 1'b1;
                        press_t[ch] = cyc;
                    end else begin
                        m_release[ch] = 1'b1;
                        press_t[ch]   = -1;
                    end
                    m_state[ch] = ~m_state[ch];
                end else if (m_state[ch] && press_t[ch] >= 0) begin
                    int d;
                    d = cyc - (press_t[ch] + LONG - 1);
                    if (d == 0) m_long[ch] = 1'b1;
`ifdef DEBOUNCER_AUTOREPEAT_EN
                    else if (d > 0 && (d % REP) == 0) m_press[ch] = 1'b1;
`endif
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int press_at;
        press_at = -1;
        rst_n = 1'b0;
        btn   = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=00000000", cyc,
                         {btn_state, btn_press, btn_release, btn_long});
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            if (i > 25) btn = 2'b00;
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (btn_press == 2'b11 && press_at < 0) press_at = i;
            if (i == 25) begin
                n_tests++;
                if (btn_state !== 2'b11) begin
                    n_fail++;
                    $display("FAIL reset_held_state got=%b exp=11", btn_state);
                end
            end
        end
        n_tests++;
        if (press_at != 18) begin
            n_fail++;
            $display("FAIL reset_held_press_latency got=%0d exp=18", press_at);
        end
    endtask

    task automatic test_glitch();
        int press_at;
        int press_cnt;
        press_at  = -1;
        press_cnt = 0;
        for (int i = 1; i <= 71; i++) begin
            btn[1] = 1'b0;
            btn[0] = (i <= 45) && !(i >= 6 && i <= 8) && !(i >= 13 && i <= 15);
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL glitch_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (btn_press[0]) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
        end
        n_tests++;
        if (press_at != 33) begin
            n_fail++;
            $display("FAIL glitch_toggle_edge got=%0d exp=33", press_at);
        end
        n_tests++;
        if (press_cnt != 1) begin
            n_fail++;
            $display("FAIL glitch_press_count got=%0d exp=1", press_cnt);
        end
    endtask

    task automatic test_long_press();
        int press_at;
        int long_at;
        int long_cnt;
        int rel_at;
        press_at = -1;
        long_at  = -1;
        long_cnt = 0;
        rel_at   = -1;
        for (int i = 1; i <= 125; i++) begin
            btn = {1'b0, (i <= 100)};
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL long_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (btn_press[0] && press_at < 0) press_at = i;
            if (btn_long[0]) begin
                long_cnt++;
                if (long_at < 0) long_at = i;
            end
            if (btn_release[0] && rel_at < 0) rel_at = i;
        end
        n_tests++;
        if (press_at != 18) begin
            n_fail++;
            $display("FAIL long_press_edge got=%0d exp=18", press_at);
        end
        n_tests++;
        if (long_at != 57 || long_cnt != 1) begin
            n_fail++;
            $display("FAIL long_pulse got_edge=%0d got_count=%0d exp_edge=57 exp_count=1", long_at, long_cnt);
        end
        n_tests++;
        if (rel_at != 118) begin
            n_fail++;
            $display("FAIL long_release_edge got=%0d exp=118", rel_at);
        end
    endtask

    task automatic test_short_press();
        int press_cnt;
        int rel_cnt;
        int long_cnt;
        press_cnt = 0;
        rel_cnt   = 0;
        long_cnt  = 0;
        for (int i = 1; i <= 60; i++) begin
            btn = {1'b0, (i <= 30)};
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL short_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (btn_press[0])   press_cnt++;
            if (btn_release[0]) rel_cnt++;
            if (btn_long[0])    long_cnt++;
        end
        n_tests++;
        if (press_cnt != 1 || rel_cnt != 1 || long_cnt != 0) begin
            n_fail++;
            $display("FAIL short_events got=%0d/%0d/%0d exp=1/1/0 (press/release/long)",
                     press_cnt, rel_cnt, long_cnt);
        end
    endtask

    task automatic test_hold80();
        int press_cnt;
        int second_at;
        int long_at;
        press_cnt = 0;
        second_at = -1;
        long_at   = -1;
        for (int i = 1; i <= 105; i++) begin
            btn = {1'b0, (i <= 80)};
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL hold80_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (btn_press[0]) begin
                press_cnt++;
                if (press_cnt == 2) second_at = i;
            end
            if (btn_long[0] && long_at < 0) long_at = i;
        end
        n_tests++;
        if (long_at != 57) begin
            n_fail++;
            $display("FAIL hold80_long_edge got=%0d exp=57", long_at);
        end
`ifdef DEBOUNCER_AUTOREPEAT_EN
        n_tests++;
        if (second_at != 67) begin
            n_fail++;
            $display("FAIL hold80_first_repeat got=%0d exp=67", second_at);
        end
`else
        n_tests++;
        if (press_cnt != 1) begin
            n_fail++;
            $display("FAIL hold80_single_press got=%0d exp=1 (second at %0d)", press_cnt, second_at);
        end
`endif
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 60; i++) begin
            btn = (i <= 30) ? 2'b11 : 2'b00;
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL simul_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (i == 18) begin
                n_tests++;
                if (btn_press !== 2'b11) begin
                    n_fail++;
                    $display("FAIL simul_press got=%b exp=11", btn_press);
                end
            end
            if (i == 48) begin
                n_tests++;
                if (btn_release !== 2'b11) begin
                    n_fail++;
                    $display("FAIL simul_release got=%b exp=11", btn_release);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int press_at;
        press_at = -1;
        for (int i = 1; i <= 70; i++) begin
            btn   = {1'b0, (i <= 45)};
            rst_n = (i == 13) ? 1'b0 : 1'b1;
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL abort_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
            if (btn_press[0] && press_at < 0) press_at = i;
        end
        rst_n = 1'b1;
        n_tests++;
        if (press_at != 31) begin
            n_fail++;
            $display("FAIL abort_restart_edge got=%0d exp=31", press_at);
        end
    endtask

    task automatic test_random();
        int dur [CH];
        bit tgt [CH];
        int bounce [CH];
        int rst_left;
        rst_left = 0;
        for (int ch = 0; ch < CH; ch++) begin
            dur[ch]    = 0;
            tgt[ch]    = 1'b0;
            bounce[ch] = 0;
        end
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (dur[ch] == 0) begin
                    tgt[ch]    = ~tgt[ch];
                    dur[ch]    = int'($urandom_range(5, 120));
                    bounce[ch] = int'($urandom_range(0, 6));
                end else begin
                    dur[ch] = dur[ch] - 1;
                end
                if (bounce[ch] > 0) begin
                    btn[ch]    = ($urandom_range(0, 1) != 0);
                    bounce[ch] = bounce[ch] - 1;
                end else begin
                    btn[ch] = tgt[ch];
                end
            end
            if (rst_left > 0) begin
                rst_n    = 1'b0;
                rst_left = rst_left - 1;
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 299) == 0) rst_left = int'($urandom_range(1, 3));
            end
            step();
            n_tests++;
            if ({btn_state, btn_press, btn_release, btn_long} !== {m_state, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc,
                         {btn_state, btn_press, btn_release, btn_long}, {m_state, m_press, m_release, m_long});
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        btn     = '0;
        m_state = '0;
        m_press = '0;
        m_release = '0;
        m_long  = '0;
        for (int ch = 0; ch < CH; ch++) press_t[ch] = -1;
        test_reset();
        test_glitch();
        test_long_press();
        test_short_press();
        test_hold80();
        test_simultaneous();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debouncer_multi.md
BUTTON_DEBOUNCER_MULTI -- requirements
Module: button_debouncer_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 5; number of independent button channels (1..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 16; debounce counter width; stable time = 2^CNT_WIDTH cycles.
REQ-003 SHALL have parameter SYNC_STAGES, default 2; input synchroniser depth (2..4).
REQ-004 SHALL have parameter LONG_CYCLES, default 50_000_000; hold time in cycles for a long-press event (>= 2).
REQ-005 SHALL have parameter REPEAT_CYCLES, default 10_000_000; auto-repeat period in cycles (>= 2), used only under DEBOUNCER_AUTOREPEAT_EN.
REQ-006 SHALL have port CLK100MHZ  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port CPU_RESETN  input  1  synchronous, active-low reset.
REQ-008 SHALL have port btn_in  input  CHANNELS  raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port btn_state  output  CHANNELS  debounced level per channel.
REQ-010 SHALL have port btn_press  output  CHANNELS  one-cycle pulse per debounced press (or repeat).
REQ-011 SHALL have port btn_release  output  CHANNELS  one-cycle pulse per debounced release.
REQ-012 SHALL have port btn_long  output  CHANNELS  one-cycle pulse when a press has been held LONG_CYCLES cycles.

Function
REQ-013 Each channel SHALL pass btn_in through a SYNC_STAGES-deep flip-flop chain; only the last stage (sync) feeds logic.
REQ-014 Per channel, debounce counter SHALL clear on every cycle sync == btn_state, and increment by 1 each cycle sync != btn_state.
REQ-015 On an edge where sync != btn_state and counter == 2^CNT_WIDTH-1, btn_state SHALL toggle and counter SHALL clear; counter never wraps.
REQ-016 Any single-cycle agreement of sync with btn_state before that point SHALL restart the count from 0 (glitch rejection).
REQ-017 btn_press (btn_release) SHALL be high for exactly the one cycle in which btn_state is first 1 (0) after a toggle; registered, same edge as btn_state.
REQ-018 Latency raw edge -> btn_state toggle SHALL be SYNC_STAGES + 2^CNT_WIDTH cycles for a clean input.
REQ-019 Per channel, hold counter SHALL clear while btn_state == 0 and increment (saturating at LONG_CYCLES) while btn_state == 1.
REQ-020 btn_long SHALL pulse for one cycle when the hold counter transitions to LONG_CYCLES-1; at most one btn_long per press.
REQ-021 Release before LONG_CYCLES SHALL produce no btn_long; release and long on the same edge is impossible by construction (state 0 clears hold).
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported on the same cycle.
REQ-023 Counter widths SHALL be $clog2 of their limits; no truncation warnings for any legal parameter set.

Reset
REQ-024 While CPU_RESETN == 0 at a clock edge, synchroniser stages, btn_state, all counters and all pulse outputs SHALL be 0.
REQ-025 Reset asserted mid-count or mid-hold SHALL abort it; no pulse SHALL be emitted on the cycle after release of reset.
REQ-026 A button held through reset release SHALL be reported as a fresh press after SYNC_STAGES + 2^CNT_WIDTH cycles.

Configuration
REQ-027 With macro DEBOUNCER_AUTOREPEAT_EN defined, after btn_long each further REPEAT_CYCLES of continuous hold SHALL produce an extra btn_press pulse, via a per-channel repeat counter cleared on release or reset.
REQ-028 Without DEBOUNCER_AUTOREPEAT_EN, no repeat counter SHALL be synthesised and btn_press SHALL pulse only once per debounced press.

Verification (CHANNELS=2, CNT_WIDTH=4, SYNC_STAGES=2, LONG_CYCLES=40, REPEAT_CYCLES=10)
REQ-029 Reset low 5 cycles with btn_in=2'b11 -> all outputs 0 during reset; btn_state=2'b11 and btn_press=2'b11 pulse exactly 18 cycles after reset release.
REQ-030 btn_in[0] 0->1 with 3-cycle low glitches at cycle 5 and 12 -> no toggle until 16 clean sync cycles after last glitch; one btn_press[0] pulse.
REQ-031 Hold btn_in[0] 100 cycles then release -> btn_press at 18, btn_long once at 40 hold cycles, btn_release 18 cycles after release; btn_long never repeats.
REQ-032 Press held 30 cycles then released -> no btn_long; press and release pulses only.
REQ-033 DEBOUNCER_AUTOREPEAT_EN defined, hold 80 cycles -> btn_press at debounce, then every 10 cycles after btn_long (hold cycles 50, 60, 70); undefined -> single btn_press.
REQ-034 CPU_RESETN pulsed low 1 cycle at debounce count 10 -> count aborted, no pulse, restart gives toggle 18 cycles after reset release.
